mem_port_arbiter: RTL and testbench

//  Shares the core's single unified memory port between instruction fetch (IF) and

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch requester, data requester, memory port and
//            pipeline stall signals that surround mem_port_arbiter.
// Modports : slave  - the arbiter (consumes requests and mem_ack/mem_rdata,
//                     produces completions, memory request and stalls)
//            master - the surrounding pipeline/memory environment
// Signals  : if_req/if_addr/if_rdata/if_valid          fetch side
//            d_req/d_we/d_addr/d_wdata/d_be/d_rdata/d_valid  data side
//            mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_ack/mem_rdata
//            stall_if/stall_mem                         hazard outputs
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall_if, stall_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between instruction fetch and the
//            load/store stage. One transaction outstanding at a time against a
//            variable-latency memory; data side has fixed priority, bounded by
//            a starvation counter that lets a waiting fetch through.
// Ports    : clk    - core clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mem_port_arbiter_if.slave (requesters, memory, stalls)
// Params   : ADDR_W, DATA_W (byte enables DATA_W/8), STARVE_LIM (>=1)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_valid;

  logic w_if_elig;
  logic w_d_elig;
  logic w_grant_d;
  logic w_grant_if;

  // A requester whose completion pulse is showing this cycle is still holding
  // its (now satisfied) request, so it must not be granted again yet.
  assign w_if_elig = bus.if_req & ~r_if_valid;
  assign w_d_elig  = bus.d_req  & ~r_d_valid;

  // Data wins unless it has used up its quota of grants over a waiting fetch.
  // If fetch is not eligible, data is never held back.
  assign w_grant_d  = w_d_elig & ((r_starve_cnt < c_starve_lim) | ~w_if_elig);
  assign w_grant_if = w_if_elig & ~w_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_if_rdata   <= '0;
      r_if_valid   <= 1'b0;
      r_d_rdata    <= '0;
      r_d_valid    <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state     <= ST_D_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            // Loads read whole words; byte enables only qualify stores.
            r_mem_be    <= bus.d_we ? bus.d_be : {BE_W{1'b1}};
            if (bus.if_req && (r_starve_cnt != c_starve_lim)) begin
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
          end else if (w_grant_if) begin
            r_state      <= ST_IF_BUSY;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= bus.if_addr;
            r_mem_wdata  <= '0;
            r_mem_be     <= {BE_W{1'b1}};
            r_starve_cnt <= '0;
          end
        end
        ST_IF_BUSY: begin
          if (bus.mem_ack) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_if_rdata <= bus.mem_rdata;
            r_if_valid <= 1'b1;
          end
        end
        ST_D_BUSY: begin
          if (bus.mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_d_rdata <= bus.mem_rdata;
            r_d_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;

  // Stalls are forced low while reset is asserted, independent of requests.
  assign bus.stall_if  = rst_n & bus.if_req & ~r_if_valid;
  assign bus.stall_mem = rst_n & bus.d_req  & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios plus
//            a randomized phase, all checked each cycle against a
//            transaction-level model of the port-sharing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int LIM    = 4;
  localparam byte G_D   = "D";
  localparam byte G_I   = "I";

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(LIM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic              m_busy = 1'b0;   // memory request expected outstanding this cycle
  logic              m_owner_d = 1'b0;
  int                m_cnt = 0;       // consecutive data grants over a waiting fetch
  int                m_lat = 0;       // cycles left before the memory acks
  logic              exp_if_v = 1'b0;
  logic              exp_d_v = 1'b0;
  logic [DATA_W-1:0] exp_rd = '0;
  logic              x_we = 1'b0;
  logic [ADDR_W-1:0] x_addr = '0;
  logic [DATA_W-1:0] x_wdata = '0;
  logic [BE_W-1:0]   x_be = '0;
  byte               glog[$];

  // Stimulus policy
  bit auto_en = 1'b0;
  bit stray_en = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int if_keep = 0;   // re-requests issued on fetch completion (directed mode)
  int d_keep  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Advance one clock and compare every DUT output against the model.
  task automatic cycle();
    logic p_if_elig, p_d_elig, p_busy, p_ack, p_if_req, p_d_we;
    logic [ADDR_W-1:0] p_if_addr, p_d_addr;
    logic [DATA_W-1:0] p_d_wdata, p_rdata;
    logic [BE_W-1:0]   p_d_be;
    p_if_req  = bus.if_req;
    p_if_elig = bus.if_req && !exp_if_v;
    p_d_elig  = bus.d_req && !exp_d_v;
    p_busy    = m_busy;
    p_ack     = bus.mem_ack;
    p_rdata   = bus.mem_rdata;
    p_if_addr = bus.if_addr;
    p_d_we    = bus.d_we;
    p_d_addr  = bus.d_addr;
    p_d_wdata = bus.d_wdata;
    p_d_be    = bus.d_be;
    @(posedge clk);
    #1;
    exp_if_v = 1'b0;
    exp_d_v  = 1'b0;
    if (p_busy) begin
      if (p_ack) begin
        m_busy = 1'b0;
        if (m_owner_d) exp_d_v = 1'b1;
        else           exp_if_v = 1'b1;
        exp_rd = p_rdata;
      end
    end else if (p_if_elig || p_d_elig) begin
      m_busy = 1'b1;
      m_lat  = int'($urandom_range(lat_max, lat_min));
      if (p_d_elig && (m_cnt < LIM || !p_if_elig)) begin
        m_owner_d = 1'b1;
        x_we = p_d_we; x_addr = p_d_addr; x_wdata = p_d_wdata;
        x_be = p_d_we ? p_d_be : '1;
        if (p_if_req && m_cnt < LIM) m_cnt++;
        glog.push_back(G_D);
      end else begin
        m_owner_d = 1'b0;
        x_we = 1'b0; x_addr = p_if_addr; x_be = '1;
        m_cnt = 0;
        glog.push_back(G_I);
      end
    end
    chk("mem_req", bus.mem_req, m_busy);
    chk("if_valid", bus.if_valid, exp_if_v);
    chk("d_valid", bus.d_valid, exp_d_v);
    if (m_busy) begin
      chk("mem_we", bus.mem_we, x_we);
      chk("mem_addr", bus.mem_addr, x_addr);
      chk("mem_be", bus.mem_be, x_be);
      if (x_we) chk("mem_wdata", bus.mem_wdata, x_wdata);
    end
    if (exp_if_v) chk("if_rdata", bus.if_rdata, exp_rd);
    if (exp_d_v)  chk("d_rdata", bus.d_rdata, exp_rd);
  endtask

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = $urandom();
  endtask

  task automatic new_d();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'($urandom_range(1, 0));
    bus.d_addr  = $urandom();
    bus.d_wdata = $urandom();
    bus.d_be    = BE_W'($urandom_range(15, 0));
  endtask

  // One full cycle: check, then act as memory and requesters, then check stalls.
  task automatic step();
    cycle();
    if (m_busy) begin
      bus.mem_ack = (m_lat == 0);
      if (m_lat > 0) m_lat--;
    end else begin
      bus.mem_ack = stray_en && ($urandom_range(5, 0) == 0);
    end
    bus.mem_rdata = $urandom();
    if (exp_if_v) begin
      if (auto_en) begin
        if ($urandom_range(1, 0) == 1) new_if(); else bus.if_req = 1'b0;
      end else if (if_keep > 0) if_keep--;
      else bus.if_req = 1'b0;
    end else if (auto_en && !bus.if_req && $urandom_range(2, 0) == 0) new_if();
    if (exp_d_v) begin
      if (auto_en) begin
        if ($urandom_range(1, 0) == 1) new_d(); else bus.d_req = 1'b0;
      end else if (d_keep > 0) d_keep--;
      else bus.d_req = 1'b0;
    end else if (auto_en && !bus.d_req && $urandom_range(2, 0) == 0) new_d();
    #1;
    chk("stall_if", bus.stall_if, bus.if_req && !exp_if_v);
    chk("stall_mem", bus.stall_mem, bus.d_req && !exp_d_v);
  endtask

  task automatic run_until(input bit want_if, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(want_if ? exp_if_v : exp_d_v) && n < max);
    if (want_if) chk("wait_if_valid", bus.if_valid, 1'b1);
    else         chk("wait_d_valid", bus.d_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b, k;
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state, with requests asserted to show stalls are suppressed
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", bus.mem_be, 4'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_d_valid", bus.d_valid, 1'b0);
    chk("rst_stall_if", bus.stall_if, 1'b0);
    chk("rst_stall_mem", bus.stall_mem, 1'b0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: lone fetch, ack one cycle after mem_req
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step();
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_we", bus.mem_we, 1'b0);
    run_until(1'b1, 20, n);
    chk("t1_latency", n + 1, 3);
    repeat (2) step();

    // 2: simultaneous fetch and store; store goes first
    b = glog.size();
    bus.if_req = 1'b1; bus.if_addr = 32'h340;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'h3;
    step();
    chk("t2_addr", bus.mem_addr, 32'h200);
    chk("t2_be", bus.mem_be, 4'h3);
    chk("t2_wdata", bus.mem_wdata, 32'hDEADBEEF);
    run_until(1'b0, 20, n);
    run_until(1'b1, 20, n);
    chk("t2_first", glog[b], G_D);
    chk("t2_second", glog[b+1], G_I);
    repeat (2) step();

    // 3: six back-to-back loads with a fetch pending. The fetch is granted at
    //    the first load's completion cycle, where the load is masked.
    b = glog.size();
    bus.if_req = 1'b1; bus.if_addr = 32'h480;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_be = 4'h1;
    d_keep = 5;
    k = 0;
    while (glog.size() < b + 7 && k < 80) begin step(); k++; end
    chk("t3_grants", 64'(glog.size() - b), 64'd7);
    chk("t3_g0", glog[b], G_D);
    chk("t3_g1", glog[b+1], G_I);
    for (int i = 2; i < 7; i++) chk("t3_gd", glog[b+i], G_D);
    run_until(1'b0, 20, n);
    repeat (2) step();

    // 4: ten-cycle memory latency on a store; fields held, one pulse
    lat_min = 10; lat_max = 10;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h7F0;
    bus.d_wdata = 32'h1234_5678; bus.d_be = 4'hC;
    run_until(1'b0, 30, n);
    chk("t4_latency", n, 12);
    repeat (3) step();

    // 5: asynchronous reset while the data transaction is outstanding
    lat_min = 8; lat_max = 8;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h900;
    bus.d_wdata = 32'hCAFE_F00D; bus.d_be = 4'hF;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_req", bus.mem_req, 1'b0);
    chk("t5_stall_mem", bus.stall_mem, 1'b0);
    chk("t5_d_valid", bus.d_valid, 1'b0);
    chk("t5_if_valid", bus.if_valid, 1'b0);
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.mem_ack = 1'b0;
    m_busy = 1'b0; m_cnt = 0; exp_if_v = 1'b0; exp_d_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat_min = 1; lat_max = 1;
    bus.mem_ack = 1'b1;
    stray_en = 1'b1;
    repeat (6) step();
    stray_en = 1'b0;

    // 6: fetch held through its completion cycle; re-granted one cycle later
    bus.if_req = 1'b1; bus.if_addr = 32'hA00;
    if_keep = 1;
    run_until(1'b1, 20, n);
    step();
    chk("t6_no_dup", bus.mem_req, 1'b0);
    step();
    chk("t6_regrant", bus.mem_req, 1'b1);
    run_until(1'b1, 20, n);
    repeat (2) step();

    // Randomized traffic, latencies and stray acks
    auto_en = 1'b1; stray_en = 1'b1; lat_min = 1; lat_max = 4;
    repeat (300) step();
    auto_en = 1'b0; stray_en = 1'b0;
    k = 0;
    while ((bus.if_req || bus.d_req || m_busy) && k < 60) begin step(); k++; end
    chk("drain", {bus.if_req, bus.d_req, bus.mem_req}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
